// File: rtl/fifo_ctrl.sv
// fifo_ctrl: single-clock FIFO controller driving an external dual-port memory, with level flags and sticky error flags.
module fifo_ctrl #(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int AF_LVL = 240,
  parameter int AE_LVL = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          pop_valid,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow,
  input  logic          clr_err,
  output logic [AW-1:0] mem_a1,
  output logic [DW-1:0] mem_wd1,
  output logic          mem_we1,
  output logic [AW-1:0] mem_a2,
  input  logic [DW-1:0] mem_rd2
);
  localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);
  localparam logic [AW:0] AF    = (AW+1)'(AF_LVL);
  localparam logic [AW:0] AE    = (AW+1)'(AE_LVL);
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic [DW-1:0] r_pop_data;
  logic          r_pop_valid, r_ovf, r_unf;
  logic          w_push_ok, w_pop_ok;
  assign full         = r_count == DEPTH;
  assign empty        = r_count == '0;
  assign almost_full  = r_count >= AF;
  assign almost_empty = r_count <= AE;
  // a pop frees a slot this cycle, so a push at full is still accepted alongside it
  assign w_pop_ok  = pop & ~empty & ~rst;
  assign w_push_ok = push & (~full | w_pop_ok) & ~rst;
  assign mem_a1    = r_wr_ptr;
  assign mem_wd1   = push_data;
  assign mem_we1   = w_push_ok;
  assign mem_a2    = r_rd_ptr;
  assign count     = r_count;
  assign pop_data  = r_pop_data;
  assign pop_valid = r_pop_valid;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_pop_data  <= '0;
      r_pop_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok) begin
        r_rd_ptr   <= r_rd_ptr + AW'(1);
        r_pop_data <= mem_rd2;
      end
      r_pop_valid <= w_pop_ok;
      if (w_push_ok != w_pop_ok) r_count <= w_push_ok ? r_count + (AW+1)'(1) : r_count - (AW+1)'(1);
      r_ovf <= (push & ~w_push_ok) | (r_ovf & ~clr_err);
      r_unf <= (pop & empty) | (r_unf & ~clr_err);
    end
  end
endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
Parameters (name, default, meaning):
REQ-001 SHALL have parameter AW, 8, address width; FIFO depth is 2^AW entries (256).
REQ-002 SHALL have parameter DW, 8, data width.
REQ-003 SHALL have parameter AF_LVL, 240, almost_full threshold (count >= AF_LVL).
REQ-004 SHALL have parameter AE_LVL, 16, almost_empty threshold (count <= AE_LVL).
Ports (name, direction, width, meaning):
REQ-005 SHALL have clk, input, 1, single clock; all state updates on posedge clk.
REQ-006 SHALL have rst, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have push, input, 1, write request; push_data, input, DW, write data.
REQ-008 SHALL have pop, input, 1, read request; pop_data, output, DW, registered read data; pop_valid, output, 1, pop_data valid strobe.
REQ-009 SHALL have full, empty, almost_full, almost_empty, output, 1 each, status flags; count, output, AW+1, occupancy 0..256.
REQ-010 SHALL have overflow, underflow, output, 1 each, sticky error flags; clr_err, input, 1, clears both sticky flags.
REQ-011 SHALL have mem_a1, output, AW; mem_wd1, output, DW; mem_we1, output, 1: write port to the dual-port memory.
REQ-012 SHALL have mem_a2, output, AW; mem_rd2, input, DW: read port to the dual-port memory (combinational read data).

Function
REQ-013 SHALL hold wr_ptr, rd_ptr (AW bits, wrap 255->0 naturally) and count (AW+1 bits).
REQ-014 SHALL accept a push when push=1 and (full=0 or an accepted pop occurs in the same cycle).
REQ-015 SHALL accept a pop when pop=1 and empty=0; a simultaneous push never makes a pop on an empty FIFO acceptable.
REQ-016 SHALL drive mem_a1=wr_ptr, mem_wd1=push_data, mem_we1=accepted push, combinationally in the accept cycle; wr_ptr increments at that clock edge.
REQ-017 SHALL drive mem_a2=rd_ptr continuously; on an accepted pop, capture mem_rd2 into pop_data and set pop_valid=1 for exactly the following cycle; rd_ptr increments at that edge.
REQ-018 SHALL hold pop_data unchanged when no pop is accepted; pop_valid=0 otherwise.
REQ-019 SHALL update count: +1 push only, -1 pop only, unchanged for both or neither.
REQ-020 SHALL derive full=(count==256), empty=(count==0), almost_full=(count>=AF_LVL), almost_empty=(count<=AE_LVL), combinationally from registered count.
REQ-021 SHALL set overflow on push=1 that is rejected (full, no accepted pop); set underflow on pop=1 while empty; flags stay set until clr_err or rst.
REQ-022 SHALL give set priority over clr_err when both occur in the same cycle.
REQ-023 SHALL never modify pointers, count or memory on a rejected request.
REQ-024 SHALL, at full with push and pop together, write to wr_ptr (== rd_ptr) while reading the old entry at the same address; the read returns pre-write data because the memory write commits at the edge.

Reset
REQ-025 SHALL, with rst=1 at a clock edge, set wr_ptr=0, rd_ptr=0, count=0, pop_data=0, pop_valid=0, overflow=0, underflow=0; empty=1, almost_empty=1, full=0, almost_full=0.
REQ-026 SHALL force mem_we1=0 while rst=1 and ignore push/pop in that cycle; reset mid-operation discards all contents (memory not cleared).

Verification
REQ-027 SHALL cover: reset, push 0x11,0x22,0x33 in consecutive cycles, then pop x3 -> pop_valid pulses each following cycle with pop_data 0x11,0x22,0x33; count 3->0; empty=1.
REQ-028 SHALL cover: 256 pushes -> full=1, count=256, almost_full set on the 240th; 257th push -> rejected, overflow=1, count stays 256.
REQ-029 SHALL cover: at full, push 0xAA + pop same cycle -> both accepted, count=256, pop_data = oldest entry, 0xAA later returned after 255 more pops.
REQ-030 SHALL cover: empty FIFO, push 0x5C + pop same cycle -> push accepted, pop rejected, underflow=1, count=1; next pop returns 0x5C.
REQ-031 SHALL cover: pointer wrap, 300 push/pop pairs of incrementing data -> data returned in order across the 255->0 boundary, count never exceeds 1.
REQ-032 SHALL cover: rst asserted with count=10 and push=1 -> next cycle count=0, empty=1, mem_we1=0 during reset, sticky flags cleared; clr_err with overflow set -> overflow=0.
